// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the dataflow deadlock monitor hierarchy.
// Holds the stall-vector widths, the watchdog state encoding and the snapshot record.
package deadlock_mon_pkg;

    localparam int unsigned AXIS_N = 12;
    localparam int unsigned IDLE_N = 6;
    localparam int unsigned BLK_N  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        TRIPPED
    } dlw_state_t;

    typedef struct packed {
        logic [AXIS_N-1:0] axis;
        logic [IDLE_N-1:0] idle;
        logic [BLK_N-1:0]  blk;
    } dlw_snap_t;

endpackage

// File: rtl/dlw_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dlw_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/deadlock_watchdog.sv
// Qualifies the registered deadlock verdict over a programmable run length, then latches a
// sticky flag, a snapshot of the stall vectors and the cycle timestamp of the tripping sample.
module deadlock_watchdog #(
    parameter int unsigned THRESH_W = 16,
    parameter int unsigned TS_W     = 32,
    parameter int unsigned EVT_W    = 8,
    parameter int unsigned AXIS_N   = deadlock_mon_pkg::AXIS_N,
    parameter int unsigned IDLE_N   = deadlock_mon_pkg::IDLE_N,
    parameter int unsigned BLK_N    = deadlock_mon_pkg::BLK_N
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                block,
    input  logic [AXIS_N-1:0]   axis_block_sigs,
    input  logic [IDLE_N-1:0]   inst_idle_sigs,
    input  logic [BLK_N-1:0]    inst_block_sigs,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                clear,
    output logic                deadlock,
    output logic                deadlock_pulse,
    output logic [AXIS_N-1:0]   snap_axis,
    output logic [IDLE_N-1:0]   snap_idle,
    output logic [BLK_N-1:0]    snap_block,
    output logic [TS_W-1:0]     trip_time,
    output logic [THRESH_W-1:0] run_cycles,
    output logic [EVT_W-1:0]    event_count
);

    import deadlock_mon_pkg::*;

    dlw_state_t          state_q;
    dlw_state_t          state_d;
    logic [THRESH_W-1:0] thr_eff;
    logic [THRESH_W-1:0] thr_last;
    logic                run_clr;
    logic                run_inc;
    logic                trip;
    logic                pulse_q;
    logic [AXIS_N-1:0]   snap_axis_q;
    logic [IDLE_N-1:0]   snap_idle_q;
    logic [BLK_N-1:0]    snap_block_q;
    logic [TS_W-1:0]     trip_time_q;
    logic [TS_W-1:0]     ts_q;

    // A zero threshold behaves as one so a single high sample still trips.
    always_comb begin
        thr_eff  = (threshold == '0) ? THRESH_W'(1) : threshold;
        thr_last = thr_eff - THRESH_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!clear && block) begin
                    state_d = (thr_eff == THRESH_W'(1)) ? TRIPPED : ARMING;
                end
            end
            ARMING: begin
                if (clear || !block) begin
                    state_d = IDLE;
                end else if (run_cycles >= thr_last) begin
                    state_d = TRIPPED;
                end
            end
            TRIPPED: begin
                if (clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trip    = (state_q != TRIPPED) && (state_d == TRIPPED);
        run_inc = !clear && block && (state_q != TRIPPED);
        run_clr = clear || ((state_q == ARMING) && !block);
    end

    dlw_sat_counter #(
        .WIDTH (THRESH_W)
    ) u_run_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (run_clr),
        .inc     (run_inc),
        .count   (run_cycles)
    );

    dlw_sat_counter #(
        .WIDTH (EVT_W)
    ) u_event_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (trip),
        .count   (event_count)
    );

    // Snapshot and timestamp come from the very sample that causes the trip.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q      <= 1'b0;
            snap_axis_q  <= '0;
            snap_idle_q  <= '0;
            snap_block_q <= '0;
            trip_time_q  <= '0;
            ts_q         <= '0;
        end else begin
            pulse_q <= trip;
            ts_q    <= ts_q + 1'b1;
            if (trip) begin
                snap_axis_q  <= axis_block_sigs;
                snap_idle_q  <= inst_idle_sigs;
                snap_block_q <= inst_block_sigs;
                trip_time_q  <= ts_q;
            end
        end
    end

    assign deadlock       = (state_q == TRIPPED);
    assign deadlock_pulse = pulse_q;
    assign snap_axis      = snap_axis_q;
    assign snap_idle      = snap_idle_q;
    assign snap_block     = snap_block_q;
    assign trip_time      = trip_time_q;

endmodule

// File: tb/tb_deadlock_watchdog.sv
// Scoreboard bench for deadlock_watchdog: trips are predicted into a queue and popped by a
// monitor on each deadlock_pulse; state and counters are checked directly from the stimulus.
module tb_deadlock_watchdog;

    import deadlock_mon_pkg::*;

    localparam int unsigned THRESH_W = 16;
    localparam int unsigned TS_W     = 32;
    localparam int unsigned EVT_W    = 8;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b0;
    logic                block   = 1'b0;
    logic [AXIS_N-1:0]   axis_block_sigs = '0;
    logic [IDLE_N-1:0]   inst_idle_sigs  = '0;
    logic [BLK_N-1:0]    inst_block_sigs = '0;
    logic [THRESH_W-1:0] threshold = '0;
    logic                clear = 1'b0;
    logic                deadlock;
    logic                deadlock_pulse;
    logic [AXIS_N-1:0]   snap_axis;
    logic [IDLE_N-1:0]   snap_idle;
    logic [BLK_N-1:0]    snap_block;
    logic [TS_W-1:0]     trip_time;
    logic [THRESH_W-1:0] run_cycles;
    logic [EVT_W-1:0]    event_count;

    // Small instance for counter saturation.
    logic              s_block = 1'b0;
    logic              s_clear = 1'b0;
    logic [2:0]        s_threshold = 3'd1;
    logic [AXIS_N-1:0] s_axis = '0;
    logic [IDLE_N-1:0] s_idle = '0;
    logic [BLK_N-1:0]  s_blk  = '0;
    logic              s_deadlock;
    logic              s_pulse;
    logic [AXIS_N-1:0] s_snap_axis;
    logic [IDLE_N-1:0] s_snap_idle;
    logic [BLK_N-1:0]  s_snap_block;
    logic [TS_W-1:0]   s_trip_time;
    logic [2:0]        s_run_cycles;
    logic [1:0]        s_event_count;

    typedef struct {
        logic [TS_W-1:0]  ts;
        dlw_snap_t        snap;
        logic [EVT_W-1:0] evt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    deadlock_watchdog #(
        .THRESH_W (THRESH_W),
        .TS_W     (TS_W),
        .EVT_W    (EVT_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .block           (block),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .threshold       (threshold),
        .clear           (clear),
        .deadlock        (deadlock),
        .deadlock_pulse  (deadlock_pulse),
        .snap_axis       (snap_axis),
        .snap_idle       (snap_idle),
        .snap_block      (snap_block),
        .trip_time       (trip_time),
        .run_cycles      (run_cycles),
        .event_count     (event_count)
    );

    deadlock_watchdog #(
        .THRESH_W (3),
        .TS_W     (TS_W),
        .EVT_W    (2)
    ) dut_small (
        .clock           (clock),
        .reset_n         (reset_n),
        .block           (s_block),
        .axis_block_sigs (s_axis),
        .inst_idle_sigs  (s_idle),
        .inst_block_sigs (s_blk),
        .threshold       (s_threshold),
        .clear           (s_clear),
        .deadlock        (s_deadlock),
        .deadlock_pulse  (s_pulse),
        .snap_axis       (s_snap_axis),
        .snap_idle       (s_snap_idle),
        .snap_block      (s_snap_block),
        .trip_time       (s_trip_time),
        .run_cycles      (s_run_cycles),
        .event_count     (s_event_count)
    );

    always #5 clock = ~clock;

    // Bench cycle count: equals the DUT timestamp of the sample taken at the next edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Predict a trip on the next sample using the inputs currently driven.
    task automatic expect_trip(input logic [EVT_W-1:0] evt);
        exp_t e;
        e.ts        = TS_W'(cyc);
        e.snap.axis = axis_block_sigs;
        e.snap.idle = inst_idle_sigs;
        e.snap.blk  = inst_block_sigs;
        e.evt       = evt;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (reset_n && deadlock_pulse) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_trip: got pulse with trip_time 0x%0h, expected none",
                         trip_time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_trip_time", 64'(trip_time), 64'(mon_e.ts));
                check("sb_snap", 64'({snap_axis, snap_idle, snap_block}), 64'(mon_e.snap));
                check("sb_event_count", 64'(event_count), 64'(mon_e.evt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        threshold = 16'd4;
        #12;
        check("rst_deadlock", 64'(deadlock), 64'(0));
        check("rst_pulse", 64'(deadlock_pulse), 64'(0));
        check("rst_run", 64'(run_cycles), 64'(0));
        check("rst_event", 64'(event_count), 64'(0));
        check("rst_snap", 64'({snap_axis, snap_idle, snap_block}), 64'(0));
        check("rst_trip_time", 64'(trip_time), 64'(0));
        reset_n = 1'b1;
        step();

        // Three high samples under a threshold of four: no trip, count drops back.
        block = 1'b1;
        repeat (3) step();
        check("run_3", 64'(run_cycles), 64'(3));
        check("no_trip_3", 64'(deadlock), 64'(0));
        block = 1'b0;
        step();
        check("run_zero", 64'(run_cycles), 64'(0));
        check("idle_no_trip", 64'(deadlock), 64'(0));

        // Four high samples: trip with snapshot from the fourth.
        block = 1'b1;
        repeat (3) step();
        check("pre_trip", 64'(deadlock), 64'(0));
        axis_block_sigs = 12'hA5C;
        inst_idle_sigs  = 6'h2B;
        inst_block_sigs = 3'b101;
        expect_trip(8'd1);
        step();
        check("trip_deadlock", 64'(deadlock), 64'(1));
        check("trip_pulse", 64'(deadlock_pulse), 64'(1));
        check("trip_event", 64'(event_count), 64'(1));
        check("trip_run", 64'(run_cycles), 64'(4));
        axis_block_sigs = 12'h123;
        inst_idle_sigs  = 6'h11;
        inst_block_sigs = 3'b010;
        step();
        check("pulse_one_cycle", 64'(deadlock_pulse), 64'(0));
        check("sticky", 64'(deadlock), 64'(1));
        check("snap_held", 64'(snap_axis), 64'(12'hA5C));
        check("run_frozen", 64'(run_cycles), 64'(4));

        // Clear and block together: clear wins, retrip two samples later.
        threshold = 16'd2;
        clear     = 1'b1;
        step();
        clear = 1'b0;
        check("clr_deadlock", 64'(deadlock), 64'(0));
        check("clr_run", 64'(run_cycles), 64'(0));
        check("clr_snap_kept", 64'(snap_axis), 64'(12'hA5C));
        step();
        check("rearm_run", 64'(run_cycles), 64'(1));
        check("rearm_no_trip", 64'(deadlock), 64'(0));
        expect_trip(8'd2);
        step();
        check("retrip", 64'(deadlock), 64'(1));

        // Threshold of zero acts as one.
        block = 1'b0;
        clear = 1'b1;
        step();
        clear           = 1'b0;
        threshold       = 16'd0;
        axis_block_sigs = 12'h3C3;
        inst_idle_sigs  = 6'h05;
        inst_block_sigs = 3'b011;
        block           = 1'b1;
        expect_trip(8'd3);
        step();
        check("thr0_trip", 64'(deadlock), 64'(1));
        check("thr0_run", 64'(run_cycles), 64'(1));
        block           = 1'b0;
        axis_block_sigs = '0;
        step();
        check("thr0_sticky", 64'(deadlock), 64'(1));
        check("thr0_pulse_off", 64'(deadlock_pulse), 64'(0));

        // Lowering the threshold mid-run trips on the next high sample.
        clear = 1'b1;
        step();
        clear     = 1'b0;
        threshold = 16'd8;
        block     = 1'b1;
        repeat (3) step();
        check("live_run3", 64'(run_cycles), 64'(3));
        check("live_no_trip", 64'(deadlock), 64'(0));
        threshold = 16'd2;
        expect_trip(8'd4);
        step();
        check("live_trip", 64'(deadlock), 64'(1));
        check("live_run4", 64'(run_cycles), 64'(4));
        block = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("live_event", 64'(event_count), 64'(4));
        check("live_cleared", 64'(deadlock), 64'(0));

        // Narrow counters saturate.
        for (int i = 0; i < 5; i++) begin
            s_block = 1'b1;
            step();
            s_block = 1'b0;
            s_clear = 1'b1;
            step();
            s_clear = 1'b0;
            check("evt_sat", 64'(s_event_count), (i < 3) ? 64'(i + 1) : 64'(3));
        end
        s_threshold = 3'd7;
        s_block     = 1'b1;
        repeat (6) step();
        check("thr7_run6", 64'(s_run_cycles), 64'(6));
        check("thr7_no_trip", 64'(s_deadlock), 64'(0));
        s_block = 1'b0;
        step();
        check("thr7_drop_run", 64'(s_run_cycles), 64'(0));
        check("thr7_drop_trip", 64'(s_deadlock), 64'(0));

        // Asynchronous reset mid-ARMING.
        threshold = 16'd10;
        block     = 1'b1;
        repeat (3) step();
        check("arm_run3", 64'(run_cycles), 64'(3));
        #2 reset_n = 1'b0;
        #1;
        check("arst_arm_run", 64'(run_cycles), 64'(0));
        check("arst_arm_event", 64'(event_count), 64'(0));
        check("arst_arm_snap_idle", 64'(snap_idle), 64'(0));
        check("arst_arm_trip_time", 64'(trip_time), 64'(0));
        block = 1'b0;
        #2 reset_n = 1'b1;
        step();

        // Asynchronous reset in TRIPPED; timestamp restarts from zero.
        threshold       = 16'd1;
        block           = 1'b1;
        axis_block_sigs = 12'hFFF;
        expect_trip(8'd1);
        step();
        check("post_rst_trip", 64'(deadlock), 64'(1));
        step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_trip_deadlock", 64'(deadlock), 64'(0));
        check("arst_trip_pulse", 64'(deadlock_pulse), 64'(0));
        check("arst_trip_snap", 64'(snap_axis), 64'(0));
        check("arst_trip_time", 64'(trip_time), 64'(0));
        check("arst_trip_event", 64'(event_count), 64'(0));
        check("arst_trip_run", 64'(run_cycles), 64'(0));

        block   = 1'b0;
        reset_n = 1'b1;
        step();
        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
